// File: rtl/rom_fetch_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_fetch_arbiter_pkg
// Description : Shared widths, bus constants and arbiter state encoding for
//               the instruction-ROM fetch arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package rom_fetch_arbiter_pkg;

  localparam int c_inst_addr_w = 32;           // byte address bus width
  localparam int c_inst_w      = 32;           // instruction / ROM word width

  localparam logic [c_inst_addr_w-1:0] c_zero_word    = '0;
  localparam logic                     c_chip_enable  = 1'b1;
  localparam logic                     c_chip_disable = 1'b0;

  // Last-owner tracking; debug/coverage visibility only.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_I    = 2'b01,
    ARB_D    = 2'b10
  } arb_state_e;

endpackage : rom_fetch_arbiter_pkg
`default_nettype wire

// File: rtl/rom_fetch_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_fetch_arbiter_if
// Description : Requester-side bundle of the ROM fetch arbiter.
//               I port = IF-stage fetch, D port = MEM-stage code-region load.
//   *_req/*_addr   : request and byte address (requester -> arbiter)
//   *_gnt          : combinational grant     (arbiter -> requester)
//   *_rvalid/rdata : registered response     (arbiter -> requester)
//   stallreq_*     : stall requests toward ctrl for the losing requester
// Revision    : 1.0  initial release
// ============================================================================
interface rom_fetch_arbiter_if;
  import rom_fetch_arbiter_pkg::*;

  logic                     i_req;
  logic [c_inst_addr_w-1:0] i_addr;
  logic                     i_gnt;
  logic                     i_rvalid;
  logic [c_inst_w-1:0]      i_rdata;

  logic                     d_req;
  logic [c_inst_addr_w-1:0] d_addr;
  logic                     d_gnt;
  logic                     d_rvalid;
  logic [c_inst_w-1:0]      d_rdata;

  logic                     stallreq_if;
  logic                     stallreq_mem;

  // Pipeline side (pc_reg/if_id and mem stage together).
  modport master (
    output i_req, i_addr, d_req, d_addr,
    input  i_gnt, i_rvalid, i_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  stallreq_if, stallreq_mem
  );

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_addr,
    output i_gnt, i_rvalid, i_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output stallreq_if, stallreq_mem
  );

endinterface : rom_fetch_arbiter_if
`default_nettype wire

// File: rtl/rom_fetch_arbiter_burst_limiter.sv
`default_nettype none
// ============================================================================
// Module      : arb_burst_limiter
// Description : Counts consecutive D grants taken while I is waiting and
//               raises force_i once MAX_D_BURST of them have been taken.
//   clk, rst   : clock, asynchronous active-high reset
//   i_req      : I is requesting this cycle
//   i_gnt      : I granted this cycle
//   d_gnt      : D granted this cycle
//   force_i    : I must win the next conflict
//   burst_cnt  : current count (debug)
//   CNT_W must satisfy 2**CNT_W > MAX_D_BURST.
// Revision    : 1.0  initial release
// ============================================================================
module arb_burst_limiter #(
  parameter int MAX_D_BURST = 4,
  parameter int CNT_W       = 3
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_req,
  input  wire logic             i_gnt,
  input  wire logic             d_gnt,
  output logic                  force_i,
  output logic [CNT_W-1:0]      burst_cnt
);

  localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_D_BURST);
  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Any I service or I going quiet ends the starvation episode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      r_cnt <= '0;
    end else if (d_gnt && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + c_one;
    end
  end

  assign force_i   = (r_cnt == c_max);
  assign burst_cnt = r_cnt;

endmodule : arb_burst_limiter
`default_nettype wire

// File: rtl/rom_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_fetch_arbiter
// Description : Shares the single-ported, combinational-read instruction ROM
//               between the IF fetch port (I) and code-region loads (D).
//               D wins conflicts unless it has already taken MAX_D_BURST
//               grants in a row while I waited. The ROM word is registered
//               into the winner's response one cycle later.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : kills an I response being captured or being presented
//   bus        : requester bundle (slave modport)
//   rom_ce     : ROM enable, active while any port is granted
//   rom_addr   : winner's byte address, zero when idle
//   rom_inst   : ROM read word for rom_addr (same cycle)
//   arb_state  : last owner (debug)
//   burst_cnt  : consecutive D grants while I waits (debug)
// Revision    : 1.0  initial release
// ============================================================================
module rom_fetch_arbiter
  import rom_fetch_arbiter_pkg::*;
#(
  parameter int MAX_D_BURST = 4,
  parameter int CNT_W       = 3
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     flush,
  rom_fetch_arbiter_if.slave            bus,
  output logic                          rom_ce,
  output logic [c_inst_addr_w-1:0]      rom_addr,
  input  wire logic [c_inst_w-1:0]      rom_inst,
  output arb_state_e                    arb_state,
  output logic [CNT_W-1:0]              burst_cnt
);

  logic                w_force_i;
  logic                w_i_gnt;
  logic                w_d_gnt;
  logic                w_i_capture;
  logic                r_i_rvalid;
  logic                r_d_rvalid;
  logic [c_inst_w-1:0] r_i_rdata;
  logic [c_inst_w-1:0] r_d_rdata;
  arb_state_e          r_state;
  arb_state_e          w_state_next;

  arb_burst_limiter #(
    .MAX_D_BURST (MAX_D_BURST),
    .CNT_W       (CNT_W)
  ) u_burst_limiter (
    .clk       (clk),
    .rst       (rst),
    .i_req     (bus.i_req),
    .i_gnt     (w_i_gnt),
    .d_gnt     (w_d_gnt),
    .force_i   (w_force_i),
    .burst_cnt (burst_cnt)
  );

  // Grants are held off during reset so the ROM stays disabled; they depend
  // only on requests and the burst limit, never on the stall outputs.
  assign w_i_gnt = ~rst & bus.i_req & (~bus.d_req | w_force_i);
  assign w_d_gnt = ~rst & bus.d_req & ~w_i_gnt;

  assign bus.i_gnt        = w_i_gnt;
  assign bus.d_gnt        = w_d_gnt;
  assign bus.stallreq_if  = bus.i_req & ~w_i_gnt;
  assign bus.stallreq_mem = bus.d_req & ~w_d_gnt;

  assign rom_ce   = (w_i_gnt | w_d_gnt) ? c_chip_enable : c_chip_disable;
  assign rom_addr = w_i_gnt ? bus.i_addr :
                    w_d_gnt ? bus.d_addr : c_zero_word;

  // A flushed I grant still occupies the ROM but its word is discarded.
  assign w_i_capture = w_i_gnt & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_i_rvalid <= w_i_capture;
      r_d_rvalid <= w_d_gnt;
      if (w_i_capture) begin
        r_i_rdata <= rom_inst;
      end
      if (w_d_gnt) begin
        r_d_rdata <= rom_inst;
      end
    end
  end

  // A flush arriving while a fetched word is presented squashes it at once.
  assign bus.i_rvalid = r_i_rvalid & ~flush;
  assign bus.i_rdata  = r_i_rdata;
  assign bus.d_rvalid = r_d_rvalid;
  assign bus.d_rdata  = r_d_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = ARB_IDLE;
    if (w_i_gnt) begin
      w_state_next = ARB_I;
    end else if (w_d_gnt) begin
      w_state_next = ARB_D;
    end
  end

  assign arb_state = r_state;

endmodule : rom_fetch_arbiter
`default_nettype wire

// File: tb/tb_rom_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_fetch_arbiter
// Description : Directed self-checking bench for rom_fetch_arbiter with a
//               behavioural ROM and per-port response scoreboards.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rom_fetch_arbiter;
  import rom_fetch_arbiter_pkg::*;

  localparam int MAX_D_BURST = 4;
  localparam int CNT_W       = 3;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             rom_ce;
  logic [31:0]      rom_addr;
  logic [31:0]      rom_inst;
  arb_state_e       arb_state;
  logic [CNT_W-1:0] burst_cnt;

  logic [31:0] mem [64];
  logic [31:0] i_q [$];
  logic [31:0] d_q [$];

  int checks = 0;
  int errors = 0;

  rom_fetch_arbiter_if bus ();

  rom_fetch_arbiter #(
    .MAX_D_BURST (MAX_D_BURST),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .rom_ce    (rom_ce),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst),
    .arb_state (arb_state),
    .burst_cnt (burst_cnt)
  );

  assign rom_inst = mem[rom_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One arbitration cycle: drive after the falling edge, check the
  // combinational grant side, then check the registered response after the
  // rising edge against the scoreboard.
  task automatic cyc(input logic ir, input logic [31:0] ia,
                     input logic dr, input logic [31:0] da,
                     input logic fl, input logic eig, input logic edg,
                     input string tag);
    logic        exp_iv;
    logic        exp_dv;
    logic [31:0] exp_addr;
    @(negedge clk);
    bus.i_req  = ir;
    bus.i_addr = ia;
    bus.d_req  = dr;
    bus.d_addr = da;
    flush      = fl;
    #1;
    exp_addr = eig ? ia : (edg ? da : 32'h0);
    chk({tag, " i_gnt"},        32'(bus.i_gnt),        32'(eig));
    chk({tag, " d_gnt"},        32'(bus.d_gnt),        32'(edg));
    chk({tag, " stallreq_if"},  32'(bus.stallreq_if),  32'(ir & ~eig));
    chk({tag, " stallreq_mem"}, 32'(bus.stallreq_mem), 32'(dr & ~edg));
    chk({tag, " rom_ce"},       32'(rom_ce),           32'(eig | edg));
    chk({tag, " rom_addr"},     rom_addr,              exp_addr);
    exp_iv = eig & ~fl;
    exp_dv = edg;
    if (exp_iv) i_q.push_back(mem[ia[7:2]]);
    if (exp_dv) d_q.push_back(mem[da[7:2]]);
    @(posedge clk);
    #1;
    chk({tag, " i_rvalid"}, 32'(bus.i_rvalid), 32'(exp_iv));
    chk({tag, " d_rvalid"}, 32'(bus.d_rvalid), 32'(exp_dv));
    if (exp_iv && i_q.size() > 0) chk({tag, " i_rdata"}, bus.i_rdata, i_q.pop_front());
    if (exp_dv && d_q.size() > 0) chk({tag, " d_rdata"}, bus.d_rdata, d_q.pop_front());
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'hC0DE_0000 ^ (32'(k) * 32'h0101_1003);

    rst        = 1'b1;
    flush      = 1'b0;
    bus.i_req  = 1'b0;
    bus.i_addr = 32'h0;
    bus.d_req  = 1'b0;
    bus.d_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset i_rvalid",  32'(bus.i_rvalid), 32'h0);
    chk("reset d_rvalid",  32'(bus.d_rvalid), 32'h0);
    chk("reset rom_ce",    32'(rom_ce),       32'h0);
    chk("reset rom_addr",  rom_addr,          32'h0);
    chk("reset state",     32'(arb_state),    32'(ARB_IDLE));
    chk("reset burst_cnt", 32'(burst_cnt),    32'h0);
    @(negedge clk);
    rst = 1'b0;

    // I only, back to back.
    cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "ionly0");
    cyc(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "ionly1");
    cyc(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "ionly2");
    chk("ionly state", 32'(arb_state), 32'(ARB_I));

    // Conflict: D wins, I stalls.
    cyc(1'b1, 32'hC, 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, "conflict");
    chk("conflict state",     32'(arb_state), 32'(ARB_D));
    chk("conflict burst_cnt", 32'(burst_cnt), 32'h1);

    // Idle: I dropping clears the burst count.
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "idle");
    chk("idle state",     32'(arb_state), 32'(ARB_IDLE));
    chk("idle burst_cnt", 32'(burst_cnt), 32'h0);

    // Starvation cap: D,D,D,D,I,D,D,D,D,I.
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 32'h40, 1'b1, 32'h80 + 32'(4 * k), 1'b0,
          (k == 4 || k == 9), !(k == 4 || k == 9), $sformatf("cap%0d", k));
      if (k == 3) chk("cap saturated burst_cnt", 32'(burst_cnt), 32'(MAX_D_BURST));
    end
    chk("cap cleared burst_cnt", 32'(burst_cnt), 32'h0);

    // Flush: flushed fetch delivers nothing, next fetch delivers mem[9].
    cyc(1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, "flush_grant");
    cyc(1'b1, 32'h24, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "flush_next");
    chk("flush_next data", bus.i_rdata, mem[9]);
    // Flush raised while the word is presented squashes i_rvalid at once.
    bus.i_req = 1'b0;
    flush     = 1'b1;
    #1;
    chk("flush comb i_rvalid", 32'(bus.i_rvalid), 32'h0);
    // D is unaffected by flush.
    cyc(1'b0, 32'h0, 1'b1, 32'h30, 1'b1, 1'b0, 1'b1, "flush_d");

    // Reset mid-run with both responses pending and a nonzero burst count.
    cyc(1'b1, 32'h28, 1'b1, 32'h34, 1'b0, 1'b0, 1'b1, "pre_rst");
    chk("pre_rst burst_cnt", 32'(burst_cnt), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst d_rvalid",  32'(bus.d_rvalid), 32'h0);
    chk("midrst i_rvalid",  32'(bus.i_rvalid), 32'h0);
    chk("midrst rom_ce",    32'(rom_ce),       32'h0);
    chk("midrst burst_cnt", 32'(burst_cnt),    32'h0);
    chk("midrst state",     32'(arb_state),    32'(ARB_IDLE));
    @(negedge clk);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    #1;
    rst = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "post_rst");

    chk("i scoreboard empty", 32'(i_q.size()), 32'h0);
    chk("d scoreboard empty", 32'(d_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rom_fetch_arbiter
`default_nettype wire
